// File: rtl/bram_stream_loader.sv
// bram_stream_loader: fills a banked BRAM's port A round-robin from one AXI-Stream source
module bram_stream_loader #(
  parameter int BANKS = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int ADDR  = $clog2(DEPTH),
  parameter int WE    = WIDTH / 8,
  parameter int CNT_W = $clog2(BANKS * DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR-1:0]          cfg_base,
  input  logic [CNT_W-1:0]         cfg_len,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               err,
  output logic [CNT_W-1:0]         loaded_cnt,
  input  logic [WIDTH-1:0]         s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [BANKS-1:0]         ena,
  output logic [BANKS*WE-1:0]      wea,
  output logic [BANKS*ADDR-1:0]    addra,
  output logic [BANKS*WIDTH-1:0]   dina
);
  localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(BANKS * DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;
  state_t state, state_nx;
  logic [ADDR-1:0] base, row, addr_q;
  logic [CNT_W-1:0] len;
  logic [BW-1:0] bank;
  logic [WIDTH-1:0] data_q;
  logic hs, last_beat, cfg_ok, bank_wrap;
  assign busy = state == LOAD;
  assign s_axis_tready = busy;
  assign done = state == FIN;
  assign hs = s_axis_tvalid & s_axis_tready;
  assign last_beat = loaded_cnt + CNT_W'(1) == len;
  assign cfg_ok = cfg_len != '0 && cfg_len <= MAX_LEN;
  assign bank_wrap = bank == BW'(BANKS - 1);
  assign addra = {BANKS{addr_q}};
  assign dina = {BANKS{data_q}};
  for (genvar b = 0; b < BANKS; b++) begin : g_we
    assign wea[b*WE +: WE] = {WE{ena[b]}};
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state: invalid lengths skip straight to FIN; a load ends on tlast or on the len-th beat
  always_comb begin
    state_nx = state == IDLE ? (start ? (cfg_ok ? LOAD : FIN) : IDLE) :
               state == LOAD ? (hs && (s_axis_tlast || last_beat) ? FIN : LOAD) : IDLE;
  end
  // config capture, bank/row pointers, error flags and the registered write bus
  always_ff @(posedge clk) begin
    if (rst) begin
      base       <= '0;
      len        <= '0;
      row        <= '0;
      bank       <= '0;
      err        <= '0;
      loaded_cnt <= '0;
      ena        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      ena <= hs ? BANKS'(1) << bank : '0;
      if (hs) begin
        addr_q     <= base + row;
        data_q     <= s_axis_tdata;
        bank       <= bank_wrap ? '0 : bank + 1'b1;
        row        <= bank_wrap ? row + 1'b1 : row;
        loaded_cnt <= loaded_cnt + CNT_W'(1);
        if (s_axis_tlast || last_beat)
          err <= {last_beat & ~s_axis_tlast, s_axis_tlast & ~last_beat};
      end
      if (state == IDLE && start) begin
        base       <= cfg_base;
        len        <= cfg_len;
        err        <= cfg_ok ? 2'b00 : 2'b10;
        loaded_cnt <= '0;
        row        <= '0;
        bank       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bram_stream_loader.sv
// tb_bram_stream_loader: randomized load scenarios checked against a word-index model of the interleave
module tb_bram_stream_loader;
  localparam int BANKS = 4, WIDTH = 16, DEPTH = 256, ADDR = 8, WE = 2, CNT_W = 11;
  localparam int MAX = BANKS * DEPTH;
  logic clk = 0, rst = 1, start = 0;
  logic [ADDR-1:0] cfg_base = '0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic busy, done, s_axis_tready;
  logic [1:0] err;
  logic [CNT_W-1:0] loaded_cnt;
  logic [WIDTH-1:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 0, s_axis_tlast = 0;
  logic [BANKS-1:0] ena;
  logic [BANKS*WE-1:0] wea;
  logic [BANKS*ADDR-1:0] addra;
  logic [BANKS*WIDTH-1:0] dina;
  logic [ADDR-1:0] h_addr = '0;
  logic [WIDTH-1:0] h_data = '0;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  bram_stream_loader #(.BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err), .loaded_cnt(loaded_cnt),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ena"}, ena, 0);
    check({tag, "_wea"}, wea, 0);
    check({tag, "_addra"}, addra, 0);
    check({tag, "_dina"}, dina, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cnt"}, loaded_cnt, 0);
    check({tag, "_tready"}, s_axis_tready, 0);
  endtask

  // vmode: 0 = tvalid held, 1 = every other cycle, 2 = random; rst_at >= 0 resets after that many beats
  task automatic run(input int base, input int len, input int nbeats, input int last_at,
                     input int vmode, input int rst_at, input bit seq);
    logic [WIDTH-1:0] data[$];
    logic [BANKS*WE-1:0] e_wea;
    logic [1:0] e_err;
    int n_acc, k = 0, cyc = 0, e_bank = 0;
    bit pend = 0, v;
    for (int i = 0; i < nbeats; i++) data.push_back(seq ? WIDTH'(i + 1) : WIDTH'($urandom));
    if (last_at >= 0 && last_at < len) begin
      n_acc = last_at + 1;
      e_err = (last_at + 1 < len) ? 2'b01 : 2'b00;
    end else begin
      n_acc = len;
      e_err = 2'b10;
    end
    @(negedge clk);
    start = 1; cfg_base = ADDR'(base); cfg_len = CNT_W'(len);
    @(negedge clk);
    start = 0; cfg_base = ADDR'($urandom); cfg_len = CNT_W'($urandom);
    if (len < 1 || len > MAX) begin
      check("inv_done", done, 1);
      check("inv_err", err, 2'b10);
      check("inv_tready", s_axis_tready, 0);
      check("inv_ena", ena, 0);
      @(negedge clk);
      check("inv_done_end", done, 0);
      check("inv_tready_end", s_axis_tready, 0);
      check("inv_ena_end", ena, 0);
      check("inv_err_hold", err, 2'b10);
      return;
    end
    while (1) begin
      e_wea = '0;
      if (pend) e_wea[e_bank*WE +: WE] = '1;
      check("ena", ena, pend ? (64'd1 << e_bank) : 64'd0);
      check("wea", wea, e_wea);
      check("addra", addra, {BANKS{h_addr}});
      check("dina", dina, {BANKS{h_data}});
      if (k == n_acc) begin
        check("fin_done", done, 1);
        check("fin_err", err, e_err);
        check("fin_cnt", loaded_cnt, n_acc);
        check("fin_tready", s_axis_tready, 0);
        check("fin_busy", busy, 0);
        s_axis_tvalid = k < nbeats;
        s_axis_tdata = k < nbeats ? data[k] : '0;
        s_axis_tlast = 0;
        @(negedge clk);
        check("post_ena", ena, 0);
        check("post_done", done, 0);
        check("post_tready", s_axis_tready, 0);
        check("post_cnt", loaded_cnt, n_acc);
        check("post_err", err, e_err);
        s_axis_tvalid = 0;
        return;
      end
      check("load_done", done, 0);
      check("load_busy", busy, 1);
      check("load_tready", s_axis_tready, 1);
      check("load_cnt", loaded_cnt, k);
      check("load_err", err, 0);
      if (k == rst_at) begin
        rst = 1; s_axis_tvalid = 1; s_axis_tdata = WIDTH'($urandom);
        @(negedge clk);
        rst = 0; s_axis_tvalid = 0; h_addr = '0; h_data = '0;
        check_idle_zero("rst");
        @(negedge clk);
        check_idle_zero("rst2");
        return;
      end
      if (cyc++ > 4000) begin
        check("timeout", 0, 1);
        s_axis_tvalid = 0;
        return;
      end
      v = k < nbeats && (vmode == 0 || (vmode == 1 && cyc % 2 == 0) ||
                         (vmode == 2 && $urandom_range(1) == 1));
      s_axis_tvalid = v;
      s_axis_tdata = v ? data[k] : WIDTH'($urandom);
      s_axis_tlast = v && k == last_at;
      pend = v;
      if (v) begin
        e_bank = k % BANKS;
        h_addr = ADDR'((base + k / BANKS) % DEPTH);
        h_data = data[k];
        k++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int len;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 0;
    run(8'h10, 8, 8, 7, 0, -1, 1);
    run(int'($urandom_range(255)), 6, 6, 2, 0, -1, 0);
    run(int'($urandom_range(255)), 4, 6, -1, 0, -1, 0);
    run(8'hFF, 8, 8, 7, 0, -1, 0);
    run(int'($urandom_range(255)), 0, 4, -1, 0, -1, 0);
    run(int'($urandom_range(255)), 1025, 4, -1, 0, -1, 0);
    run(int'($urandom_range(255)), 8, 8, 7, 1, 3, 0);
    run(int'($urandom_range(255)), 8, 8, 7, 0, -1, 1);
    for (int t = 0; t < 12; t++) begin
      len = int'($urandom_range(20, 1));
      run(int'($urandom_range(255)), len, len + 2, int'($urandom_range(len + 1)) - 1, 2, -1, 0);
    end
    run(int'($urandom_range(255)), 1, 1, 0, 0, -1, 0);
    run(int'($urandom_range(255)), MAX, MAX, MAX - 1, 0, -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bram_stream_loader.md
Name: bram_stream_loader

Overview:
- Sequencing controller that fills a multi-bank BRAM from a single AXI-Stream source.
- Words are interleaved round-robin across banks: stream word k goes to bank k mod BANKS, at row cfg_base + k div BANKS.
- Drives the port-A write bus of the banked memory directly. Port B stays free for the compute datapath.
- Used to preload KAN coefficient/LUT tables before inference starts.

Parameters:
- BANKS, 4, number of banks; any value ≥1.
- WIDTH, 16, data width per bank; must be a multiple of 8.
- DEPTH, 256, rows per bank; must be a power of two.
- ADDR, LOG2(DEPTH), row address width.
- WE, WIDTH/8, byte-write-enable bits per bank.
- CNT_W, LOG2(BANKS*DEPTH)+1, width of word counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- cfg_base  in  ADDR  starting row, applied to all banks; captured on start.
- cfg_len  in  CNT_W  number of words to load; captured on start.
- busy  out  1  high while in LOAD.
- done  out  1  one-cycle pulse when a load terminates.
- err  out  2  bit0 = short (tlast before cfg_len words); bit1 = long (final word lacked tlast, or cfg_len invalid). Held until the next accepted start.
- loaded_cnt  out  CNT_W  number of words accepted in the current/last load.
- s_axis_tdata  in  WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- s_axis_tlast  in  1  end-of-packet marker.
- ena  out  BANKS  per-bank port-A enable; one-hot or zero.
- wea  out  BANKS*WE  per-bank byte enables.
- addra  out  BANKS*ADDR  per-bank row address; same value replicated into every slice.
- dina  out  BANKS*WIDTH  per-bank data; same word replicated into every slice.

Behaviour:
- Reset values: state IDLE; busy, done, err, loaded_cnt, s_axis_tready, ena, wea, addra, dina all 0. Reset mid-load aborts immediately: no further writes and no done pulse.
- FSM states: IDLE, LOAD, FIN.
- IDLE → LOAD on start with 1 ≤ cfg_len ≤ BANKS*DEPTH. Captures base and len, clears err and loaded_cnt, zeroes the bank pointer and row counter.
- IDLE → FIN on start with cfg_len = 0 or cfg_len > BANKS*DEPTH. Sets err = 2'b10; no stream handshake takes place.
- LOAD: s_axis_tready = 1 (registered-independent, i.e. combinational from state). A handshake is tvalid & tready.
- On each handshake:
  - Next cycle: ena has a 1 only at the current bank; that bank's WE slice is all ones and all other wea bits are 0; addra = (base + row) mod DEPTH in every slice; dina = tdata in every slice.
  - Write latency: exactly 1 cycle after the handshake. The write bus is registered.
  - The bank pointer increments; on wrap from BANKS-1 to 0, row increments. loaded_cnt increments.
- Cycles with no handshake: ena = 0 and wea = 0 on the following cycle. addra and dina hold their last values.
- Termination is evaluated on the handshake itself:
  - tlast with loaded_cnt+1 < len → err[0] = 1.
  - loaded_cnt+1 = len without tlast → err[1] = 1.
  - loaded_cnt+1 = len with tlast → clean finish, err = 0.
  - Any of these → FIN. s_axis_tready falls in the next cycle, so beats beyond len remain in the source.
- FIN: lasts one cycle. done = 1. The final write (issued from the last handshake) is presented in this same cycle. Then → IDLE.
- busy = (state == LOAD).
- start while in LOAD or FIN is ignored.
- Row address wrap: base + row beyond DEPTH-1 wraps modulo DEPTH silently; this is not an error.
- tvalid deasserting mid-load simply stalls the load; there is no timeout.

Test Plan:
- BANKS=4, base=0x10, len=8, 8 beats 0x0001..0x0008 with tlast on the 8th, tvalid held high:
  - writes: bank0@0x10=1, b1@0x10=2, b2@0x10=3, b3@0x10=4, b0@0x11=5 … b3@0x11=8 on consecutive cycles;
  - done pulses once; err = 0; loaded_cnt = 8; tready = 0 the cycle after the 8th beat.
- len=6 with tlast on beat 3 → exactly 3 writes (b0,b1,b2 @base), done, err = 2'b01, loaded_cnt = 3.
- len=4, source offers 6 beats with no tlast → 4 writes, err = 2'b10. Beats 5–6 are never accepted: tready is 0 while tvalid is 1.
- base=0xFF, len=8, DEPTH=256 → row 0 writes at 0xFF, row 1 writes at 0x00; err = 0.
- cfg_len = 0, and separately cfg_len = 1025 → no writes, tready never asserted, done pulses 1 cycle after start, err = 2'b10.
- Toggle tvalid every other cycle mid-load, then assert rst during LOAD after 3 beats:
  - ena follows the handshakes exactly, one cycle late;
  - after rst all outputs are 0, no done pulse, and a fresh start works normally.
